// File: rtl/transmissor.sv
// Serial transmitter: sends a 16-bit word as two UART byte frames (start, 8 data LSB first,
// STOP_BITS stop bits), with busy asserted throughout and a one-cycle concluded pulse at the end.
module transmissor #(
    parameter int STOP_BITS = 1
) (
    input  logic        clk_9k6hz,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] data,
    output logic        tx,
    output logic        busy,
    output logic        concluded
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic STOP_LAST = (STOP_BITS == 2);

    state_t      r_state, w_state_nx;
    logic [15:0] r_shift, w_shift_nx;
    logic        r_byte,  w_byte_nx;
    logic [2:0]  r_bit,   w_bit_nx;
    logic        r_stop,  w_stop_nx;
    logic        r_tx,    w_tx_nx;
    logic        r_busy,  w_busy_nx;
    logic        r_conc,  w_conc_nx;

    always_ff @(posedge clk_9k6hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_byte  <= 1'b0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_conc  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_byte  <= w_byte_nx;
            r_bit   <= w_bit_nx;
            r_stop  <= w_stop_nx;
            r_tx    <= w_tx_nx;
            r_busy  <= w_busy_nx;
            r_conc  <= w_conc_nx;
        end
    end

    // Outputs are computed for the state being entered, so tx/busy/concluded are plain flops.
    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_byte_nx  = r_byte;
        w_bit_nx   = r_bit;
        w_stop_nx  = r_stop;
        w_tx_nx    = 1'b1;
        w_busy_nx  = r_busy;
        w_conc_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy_nx = 1'b0;
                if (en) begin
                    w_state_nx = START;
                    w_shift_nx = data;
                    w_byte_nx  = 1'b0;
                    w_busy_nx  = 1'b1;
                    w_tx_nx    = 1'b0;
                end
            end
            START: begin
                w_state_nx = DATA;
                w_tx_nx    = r_shift[0];
                w_shift_nx = {1'b0, r_shift[15:1]};
                w_bit_nx   = 3'd0;
            end
            DATA: begin
                if (r_bit == 3'd7) begin
                    w_state_nx = STOP;
                    w_stop_nx  = 1'b0;
                end else begin
                    w_tx_nx    = r_shift[0];
                    w_shift_nx = {1'b0, r_shift[15:1]};
                    w_bit_nx   = r_bit + 3'd1;
                end
            end
            STOP: begin
                if (r_stop == STOP_LAST) begin
                    if (!r_byte) begin
                        // byte 1 follows immediately, no idle bit between frames
                        w_state_nx = START;
                        w_byte_nx  = 1'b1;
                        w_tx_nx    = 1'b0;
                    end else begin
                        w_state_nx = IDLE;
                        w_byte_nx  = 1'b0;
                        w_busy_nx  = 1'b0;
                        w_conc_nx  = 1'b1;
                    end
                end else begin
                    w_stop_nx = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign concluded = r_conc;

endmodule

// File: tb/tb_transmissor.sv
// Directed bench for transmissor: table of word/expected-line vectors plus hand-written
// sequences for back-to-back, data change, mid-frame reset and two stop bits.
module tb_transmissor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en1 = 1'b0, en2 = 1'b0;
    logic [15:0] data1 = '0, data2 = '0;
    logic        tx1, busy1, conc1, tx2, busy2, conc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    transmissor #(.STOP_BITS(1)) u_dut1 (
        .clk_9k6hz(clk), .rst_n(rst_n), .en(en1), .data(data1),
        .tx(tx1), .busy(busy1), .concluded(conc1)
    );

    transmissor #(.STOP_BITS(2)) u_dut2 (
        .clk_9k6hz(clk), .rst_n(rst_n), .en(en2), .data(data2),
        .tx(tx2), .busy(busy2), .concluded(conc2)
    );

    typedef struct {
        logic [15:0] d;
        logic [31:0] exp_tx;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sends one word on the selected DUT; bit c of exp_tx is tx in cycle c after the start edge.
    task automatic run_frame(input int which, input logic [15:0] d, input logic [31:0] exp_tx,
                             input int n, input int chg_at, input logic [15:0] chg_val);
        logic [31:0] cap;
        logic        busy_ok;
        logic [15:0] rx;
        cap = '0;
        busy_ok = 1'b1;
        @(negedge clk);
        if (which == 0) begin data1 = d; en1 = 1'b1; end
        else            begin data2 = d; en2 = 1'b1; end
        @(posedge clk);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            en1 = 1'b0;
            en2 = 1'b0;
            cap[c] = (which == 0) ? tx1 : tx2;
            if (((which == 0) ? busy1 : busy2) !== 1'b1) busy_ok = 1'b0;
            if (((which == 0) ? conc1 : conc2) !== 1'b0) busy_ok = 1'b0;
            if (c == chg_at) begin
                if (which == 0) data1 = chg_val; else data2 = chg_val;
            end
        end
        chk("frame_tx", cap, exp_tx);
        chk("frame_busy_no_conc", {31'd0, busy_ok}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            rx[i]     = cap[1 + i];
            rx[8 + i] = cap[n / 2 + 1 + i];
        end
        chk("loopback_word", {16'd0, rx}, {16'd0, d});
        @(negedge clk);
        chk("end_tx",   {31'd0, (which == 0) ? tx1 : tx2},     32'd1);
        chk("end_busy", {31'd0, (which == 0) ? busy1 : busy2}, 32'd0);
        chk("end_conc", {31'd0, (which == 0) ? conc1 : conc2}, 32'd1);
        @(negedge clk);
        chk("conc_one_cycle", {31'd0, (which == 0) ? conc1 : conc2}, 32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        int   c1, c2;
        logic tx20, tx21, b20, b21, seen;

        vecs[0] = '{16'hA55A, 32'h000D_2AB4};
        vecs[1] = '{16'h0000, 32'h0008_0200};
        vecs[2] = '{16'hFFFF, 32'h000F_FBFE};
        vecs[3] = '{16'h1234, 32'h0008_9268};

        #12;
        chk("rst_tx",   {31'd0, tx1},   32'd1);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_conc", {31'd0, conc1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tx", {31'd0, tx1}, 32'd1);

        for (int v = 0; v < 4; v++)
            run_frame(0, vecs[v].d, vecs[v].exp_tx, 20, -1, 16'h0000);

        // data changes mid-frame must not reach the line
        run_frame(0, 16'h0000, 32'h0008_0200, 20, 5, 16'hFFFF);

        // two stop bits on the second instance
        run_frame(1, 16'h0180, 32'h0030_1700, 22, -1, 16'h0000);

        // en held high: back-to-back transfers 21 cycles apart
        @(negedge clk);
        data1 = 16'h00FF;
        en1 = 1'b1;
        @(posedge clk);
        c1 = -1; c2 = -1;
        tx20 = 1'b0; tx21 = 1'b1; b20 = 1'b1; b21 = 1'b0;
        for (int c = 0; c < 60 && c2 < 0; c++) begin
            @(negedge clk);
            if (c == 20) begin tx20 = tx1; b20 = busy1; end
            if (c == 21) begin tx21 = tx1; b21 = busy1; end
            if (conc1 === 1'b1) begin
                if (c1 < 0) c1 = c;
                else begin c2 = c; en1 = 1'b0; end
            end
        end
        en1 = 1'b0;
        chk("b2b_first_conc",  c1, 20);
        chk("b2b_second_conc", c2, 41);
        chk("b2b_idle_tx",   {31'd0, tx20}, 32'd1);
        chk("b2b_idle_busy", {31'd0, b20},  32'd0);
        chk("b2b_restart_tx",   {31'd0, tx21}, 32'd0);
        chk("b2b_restart_busy", {31'd0, b21},  32'd1);
        repeat (3) @(negedge clk);

        // reset in cycle 7 aborts immediately, without a clock edge
        @(negedge clk);
        data1 = 16'hA55A;
        en1 = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            en1 = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx",   {31'd0, tx1},   32'd1);
        chk("async_rst_busy", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (conc1 === 1'b1 || busy1 === 1'b1) seen = 1'b1;
        end
        chk("post_rst_no_conc", {31'd0, seen}, 32'd0);
        run_frame(0, 16'hA55A, 32'h000D_2AB4, 20, -1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
